// File: rtl/if_stage_pkg.sv
// Shared pipeline types: fetch FSM encoding, NOP word, IF/ID entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_pkg;

  localparam int XLEN = 32;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    HOLD       = 2'd1,
    FLUSH_WAIT = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcPlus4;
  } ifIdEntry_t;

  localparam int IF_ID_W = $bits(ifIdEntry_t);

  function automatic ifIdEntry_t makeBubble(input logic [XLEN-1:0] nopWord);
    ifIdEntry_t b;
    b.valid   = 1'b0;
    b.instr   = nopWord;
    b.pcPlus4 = '0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port.
// Latency: memory-defined; ack may come in the request cycle or later.
// Backpressure: requester holds addr stable until ack.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load, bubble and hold controls.
// Latency: one cycle from load/bubble to output.
// Backpressure: holds contents when neither load nor bubble is asserted.
module if_stage_if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       bubble,
  input  ifIdEntry_t loadEntry,
  output ifIdEntry_t entry
);

  // Bubble wins over load so a redirect always squashes the slot
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      entry <= makeBubble(BUBBLE_INSTR);
    end else if (load) begin
      entry <= loadEntry;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: owns PC, drives imem req/ack, fills IF/ID.
// Latency: one cycle from ack to IF/ID with zero-wait memory.
// Backpressure: PC_IFWrite=0 parks a returned word in HOLD (req dropped).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PC_IFWrite,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  if_stage_if.master   imem,
  output logic         IF_ID_valid,
  output logic [31:0]  IF_ID_instr,
  output logic [31:0]  IF_ID_pc_plus4
);
  import if_stage_pkg::*;

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] holdBuf, holdBufNext;
  logic [31:0] savedTarget, savedTargetNext;
  logic [31:0] pcPlus4;
  logic        idLoad;
  logic        idBubble;
  ifIdEntry_t  idLoadEntry;
  ifIdEntry_t  idEntry;

  // In FLUSH_WAIT the PC is left at the old fetch address, so addr=pc
  // keeps the outstanding request stable until it is acknowledged.
  assign pcPlus4        = pc + 32'd4;
  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = pc;

  // State, PC, parked word and pending redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      holdBuf     <= '0;
      savedTarget <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      holdBuf     <= holdBufNext;
      savedTarget <= savedTargetNext;
    end
  end

  // Next-state and IF/ID control; redirect outranks the stall input
  always_comb begin
    stateNext           = state;
    pcNext              = pc;
    holdBufNext         = holdBuf;
    savedTargetNext     = savedTarget;
    idLoad              = 1'b0;
    idBubble            = 1'b0;
    idLoadEntry.valid   = 1'b1;
    idLoadEntry.instr   = imem.imem_rdata;
    idLoadEntry.pcPlus4 = pcPlus4;

    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          idBubble = 1'b1;
          if (imem.imem_ack) begin
            pcNext = branch_target;
          end else begin
            savedTargetNext = branch_target;
            stateNext       = FLUSH_WAIT;
          end
        end else if (imem.imem_ack) begin
          if (PC_IFWrite) begin
            idLoad = 1'b1;
            pcNext = pcPlus4;
          end else begin
            holdBufNext = imem.imem_rdata;
            stateNext   = HOLD;
          end
        end else if (PC_IFWrite) begin
          idBubble = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          idBubble  = 1'b1;
          pcNext    = branch_target;
          stateNext = FETCH;
        end else if (PC_IFWrite) begin
          idLoad            = 1'b1;
          idLoadEntry.instr = holdBuf;
          pcNext            = pcPlus4;
          stateNext         = FETCH;
        end
      end

      FLUSH_WAIT: begin
        idBubble = 1'b1;
        if (branch_taken) begin
          savedTargetNext = branch_target;
        end
        if (imem.imem_ack) begin
          pcNext    = branch_taken ? branch_target : savedTarget;
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  if_stage_if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (idLoad),
    .bubble    (idBubble),
    .loadEntry (idLoadEntry),
    .entry     (idEntry)
  );

  assign IF_ID_valid    = idEntry.valid;
  assign IF_ID_instr    = idEntry.instr;
  assign IF_ID_pc_plus4 = idEntry.pcPlus4;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency memory and a scoreboard.
// Latency: memory ack arrives on the lat-th cycle of a request.
// Backpressure: driven through PC_IFWrite and branch_taken steps.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_IFWrite = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc_plus4;

  if_stage_if imemBus ();

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_IFWrite     (PC_IFWrite),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imemBus.master),
    .IF_ID_valid    (IF_ID_valid),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc_plus4 (IF_ID_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory model: ack on the lat-th cycle of a request, data = addr ^ pattern
  int lat = 1;
  int waitCnt = 0;
  assign imemBus.imem_ack   = imemBus.imem_req && (waitCnt >= lat - 1);
  assign imemBus.imem_rdata = imemBus.imem_addr ^ 32'hA5A5_A5A5;

  // Counts waiting cycles of the current request
  always @(posedge clk) begin
    if (rst || !imemBus.imem_req || imemBus.imem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];
  logic        prevValid = 1'b0;
  logic [31:0] prevPc4 = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // A new IF/ID entry is a valid one that differs from what was there last cycle
  task automatic scoreboard();
    logic [31:0] e;
    if (IF_ID_valid === 1'b1 && (!prevValid || IF_ID_pc_plus4 !== prevPc4)) begin
      total++;
      assert (expQ.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_delivery: got pc_plus4 %h want none", IF_ID_pc_plus4);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("deliv_pc4", IF_ID_pc_plus4, e);
        check("deliv_instr", IF_ID_instr, (e - 32'd4) ^ 32'hA5A5_A5A5);
      end
    end else if (IF_ID_valid !== 1'b1) begin
      check("bubble_valid", {31'b0, IF_ID_valid}, 32'h0);
      check("bubble_instr", IF_ID_instr, 32'h0);
      check("bubble_pc4", IF_ID_pc_plus4, 32'h0);
    end
    prevValid = (IF_ID_valid === 1'b1);
    prevPc4   = IF_ID_pc_plus4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    scoreboard();
  endtask

  initial begin
    // reset
    step();
    step();
    check("rst_req", {31'b0, imemBus.imem_req}, 32'h0);
    check("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
    check("rst_pc4", IF_ID_pc_plus4, 32'h0);

    // zero-wait streaming
    rst = 1'b0;
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    #1;
    check("rel_req", {31'b0, imemBus.imem_req}, 32'h1);
    check("rel_addr", imemBus.imem_addr, 32'h0);
    step();
    check("stream_addr4", imemBus.imem_addr, 32'h4);
    step();
    check("stream_addr8", imemBus.imem_addr, 32'h8);

    // load-use stall for two cycles with ack at pc=8
    PC_IFWrite = 1'b0;
    step();
    check("hold_req", {31'b0, imemBus.imem_req}, 32'h0);
    check("hold_pc4", IF_ID_pc_plus4, 32'h8);
    step();
    check("hold_req2", {31'b0, imemBus.imem_req}, 32'h0);
    check("hold_pc4_2", IF_ID_pc_plus4, 32'h8);
    check("hold_valid", {31'b0, IF_ID_valid}, 32'h1);
    PC_IFWrite = 1'b1;
    expQ.push_back(32'hC);
    expQ.push_back(32'h10);
    step();
    check("release_pc4", IF_ID_pc_plus4, 32'hC);
    check("release_addr", imemBus.imem_addr, 32'hC);
    step();
    check("resume_addr", imemBus.imem_addr, 32'h10);

    // three-cycle memory: two bubbles per instruction, address stable
    lat = 3;
    expQ.push_back(32'h14);
    expQ.push_back(32'h18);
    for (int k = 0; k < 2; k++) begin
      step();
      check("lat_addr_w1", imemBus.imem_addr, 32'h10 + 32'(4 * k));
      check("lat_valid_w1", {31'b0, IF_ID_valid}, 32'h0);
      step();
      check("lat_addr_w2", imemBus.imem_addr, 32'h10 + 32'(4 * k));
      check("lat_valid_w2", {31'b0, IF_ID_valid}, 32'h0);
      step();
    end
    check("lat_next_addr", imemBus.imem_addr, 32'h18);

    // redirect while the request is still waiting
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken  = 1'b0;
    branch_target = 32'hDEAD_BEEF;
    check("fw_addr1", imemBus.imem_addr, 32'h18);
    check("fw_req1", {31'b0, imemBus.imem_req}, 32'h1);
    step();
    check("fw_addr2", imemBus.imem_addr, 32'h18);
    step();
    check("fw_target_addr", imemBus.imem_addr, 32'h100);
    check("fw_valid", {31'b0, IF_ID_valid}, 32'h0);
    lat = 1;
    expQ.push_back(32'h104);
    step();
    check("post_fw_addr", imemBus.imem_addr, 32'h104);

    // redirect while a word is parked in HOLD
    PC_IFWrite = 1'b0;
    step();
    check("hold2_req", {31'b0, imemBus.imem_req}, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    PC_IFWrite   = 1'b1;
    #1;
    check("hold_br_addr", imemBus.imem_addr, 32'h40);
    check("hold_br_req", {31'b0, imemBus.imem_req}, 32'h1);
    check("hold_br_valid", {31'b0, IF_ID_valid}, 32'h0);
    expQ.push_back(32'h44);
    step();
    check("post_hold_br_addr", imemBus.imem_addr, 32'h44);

    // redirect on an acked cycle to the top of memory; PC wraps to 0
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    check("wrap_addr", imemBus.imem_addr, 32'hFFFF_FFFC);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    step();
    check("wrap_pc", imemBus.imem_addr, 32'h0);
    step();
    check("wrap_next", imemBus.imem_addr, 32'h4);

    // reset while waiting at pc=0x20
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    step();
    branch_taken = 1'b0;
    lat = 5;
    check("pre_rst_addr", imemBus.imem_addr, 32'h20);
    step();
    check("pre_rst_addr2", imemBus.imem_addr, 32'h20);
    rst = 1'b1;
    step();
    check("midrst_req", {31'b0, imemBus.imem_req}, 32'h0);
    check("midrst_valid", {31'b0, IF_ID_valid}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_addr", imemBus.imem_addr, 32'h0);
    check("post_rst_req", {31'b0, imemBus.imem_req}, 32'h1);
    lat = 1;
    expQ.push_back(32'h4);
    step();

    check("queue_empty", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of ID and the load-use hazard detector.
- Owns the PC, drives a req/ack instruction-memory port, and fills the IF/ID pipeline register.
- Consumes PC_IFWrite from the hazard detector (0 = freeze PC and IF/ID) and the branch/jump redirect resolved in ID.
- Inserts bubbles on memory wait and on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID for a bubble (sll $0,$0,0).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
PC_IFWrite  input  1  1 = IF/ID may accept a new entry; 0 = hold PC and IF/ID (load-use stall).
branch_taken  input  1  redirect request from ID, one-cycle pulse.
branch_target  input  32  redirect PC, valid when branch_taken=1.
imem_req  output  1  instruction-memory request.
imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
imem_ack  input  1  read data valid this cycle; only meaningful when imem_req=1.
imem_rdata  input  32  instruction word, valid with imem_ack.
IF_ID_valid  output  1  IF/ID holds a real instruction.
IF_ID_instr  output  32  instruction to ID.
IF_ID_pc_plus4  output  32  PC+4 of that instruction.

Behaviour:
- Reset: rst sampled on clk edge.
  - pc<=RESET_PC, state<=FETCH, buffer cleared.
  - IF_ID_valid<=0, IF_ID_instr<=NOP_INSTR, IF_ID_pc_plus4<=0.
  - imem_req forced 0 while rst=1.
  - Reset mid-request abandons the outstanding request. Memory must tolerate this.
- imem_req = 1 in FETCH and FLUSH_WAIT, 0 in HOLD. imem_addr = pc in FETCH; the latched old address in FLUSH_WAIT.
- Priority each cycle: rst > branch_taken > PC_IFWrite.
- State FETCH:
  - ack=1, branch_taken=0, PC_IFWrite=1: IF/ID<={1, rdata, pc+4}; pc<=pc+4; stay. Zero-wait memory gives one instruction per cycle.
  - ack=1, branch_taken=0, PC_IFWrite=0: rdata latched in buffer; IF/ID unchanged; ->HOLD.
  - ack=1, branch_taken=1: data discarded; pc<=branch_target; IF/ID<=bubble; stay.
  - ack=0, branch_taken=1: target saved; IF/ID<=bubble; ->FLUSH_WAIT (address must stay stable).
  - ack=0, branch_taken=0: if PC_IFWrite=1, IF/ID<=bubble; otherwise IF/ID holds.
- State HOLD:
  - branch_taken=1: buffer discarded; pc<=branch_target; IF/ID<=bubble; ->FETCH.
  - PC_IFWrite=1: IF/ID<={1, buffer, pc+4}; pc<=pc+4; ->FETCH.
  - Otherwise hold everything.
- State FLUSH_WAIT:
  - IF/ID<=bubble every cycle.
  - On ack: data discarded; pc<=saved target; ->FETCH.
  - A second branch_taken here overwrites the saved target (latest wins).
- Bubble = {valid 0, NOP_INSTR, pc_plus4 0}.
- branch_taken flushes IF/ID even when PC_IFWrite=0.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Low two PC bits are always as loaded; no alignment check.
- No instruction is ever delivered twice or skipped. Each delivered instruction's pc_plus4 equals its fetch address + 4.

Decomposition:
- Shared pipeline package holds: state encoding (FETCH, HOLD, FLUSH_WAIT), NOP_INSTR constant, and the IF/ID entry struct/width constants (valid, instr, pc_plus4), reused by the ID stage.
- One natural sub-module: if_id_reg. It is the IF/ID register with load/bubble/hold controls and synchronous reset to bubble.
- FSM and PC stay in if_stage.

Test Plan:
- Reset then zero-wait memory (ack tied to req, rdata=addr^32'hA5A5A5A5) -> imem_addr 0,4,8,...; IF_ID_pc_plus4 4,8,12 on consecutive cycles, valid=1 from the second cycle after reset release.
- PC_IFWrite=0 for 2 cycles while ack=1 at pc=8 -> state HOLD, imem_req=0, IF/ID frozen. Instruction @8 delivered on release with pc_plus4=12, then fetch resumes at 12; no duplicate or skip.
- 3-cycle memory latency, PC_IFWrite=1 -> two bubbles (valid=0, instr=0) between instructions; imem_addr stable during wait.
- branch_taken with target 32'h100 on a cycle where ack=0 -> FLUSH_WAIT. Old address held until ack; returned data never appears in IF/ID; next request addr 32'h100.
- branch_taken during HOLD with target 32'h40 -> buffered instruction dropped, IF/ID bubble, next imem_addr=32'h40.
- rst asserted mid-wait at pc=32'h20 -> next cycle imem_req=0, IF_ID_valid=0. After release, imem_addr=RESET_PC.
